// File: rtl/game_pkg.sv
// Shared definitions for the game timer controller: FSM state encoding and scoring constants.
package game_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RUN   = 3'd1;
    localparam state_t ST_PAUSE = 3'd2;
    localparam state_t ST_SCORE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam logic [6:0]  MAX_SCORE     = 7'd100;
    localparam logic [10:0] GRACE_SECONDS = 11'd60;

endpackage

// File: rtl/game_timer_ctrl_score_eval.sv
// Combinational score from elapsed seconds: full marks inside the grace period,
// linear falloff to zero at LIMIT.
module score_eval
    import game_pkg::*;
#(
    parameter int LIMIT = 1800
) (
    input  logic [10:0] timer,
    output logic [6:0]  score
);

    localparam logic [10:0] LIMIT_V = 11'(LIMIT);
    localparam logic [17:0] SPAN    = 18'(LIMIT) - {7'd0, GRACE_SECONDS};

    logic [10:0] over_s;
    logic [17:0] prod_s;
    logic [17:0] quot_s;
    logic [10:0] quot_unused_s;

    assign quot_unused_s = quot_s[17:7];

    // Quotient stays below MAX_SCORE whenever timer lies strictly between grace and LIMIT.
    always_comb begin
        over_s = timer - GRACE_SECONDS;
        prod_s = {7'd0, over_s} * {11'd0, MAX_SCORE};
        quot_s = prod_s / SPAN;
        if (timer <= GRACE_SECONDS) begin
            score = MAX_SCORE;
        end else if (timer >= LIMIT_V) begin
            score = 7'd0;
        end else begin
            score = MAX_SCORE - quot_s[6:0];
        end
    end

endmodule

// File: rtl/game_timer_ctrl.sv
// Puzzle game timer: RUN/PAUSE timing, time-limit handling and score latching.
// Optional best-score tracking is enabled by defining GAME_TIMER_BEST_SCORE_EN.
module game_timer_ctrl
    import game_pkg::*;
#(
    parameter int CLK_HZ             = 50_000_000,
    parameter int TIME_LIMIT_MINUTES = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        pause,
    input  logic        solved,
    input  logic        abort,
    output logic [10:0] timer,
    output logic        running,
    output logic        time_up,
    output logic        done,
    output logic [6:0]  final_score,
    output logic [6:0]  best_score,
    output logic        new_record
);

    localparam int              LIMIT     = TIME_LIMIT_MINUTES * 60;
    localparam logic [10:0]     LIMIT_V   = 11'(LIMIT);
    localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nxt_s;
    logic [10:0]   timer_r;
    logic [10:0]   timer_nxt_s;
    logic [10:0]   timer_inc_s;
    logic          time_up_r;
    logic          time_up_nxt_s;
    logic [6:0]    final_score_r;
    logic          running_r;
    logic          done_r;
    logic          latch_s;
    logic [6:0]    score_s;

    score_eval #(
        .LIMIT (LIMIT)
    ) u_score_eval (
        .timer (timer_r),
        .score (score_s)
    );

    assign timer_inc_s = timer_r + 11'd1;

    // Next-state logic; abort dominates, then solved, pause, start.
    always_comb begin
        state_nxt_s   = state_r;
        presc_nxt_s   = presc_r;
        timer_nxt_s   = timer_r;
        time_up_nxt_s = time_up_r;
        latch_s       = 1'b0;
        if (abort) begin
            state_nxt_s   = ST_IDLE;
            presc_nxt_s   = '0;
            timer_nxt_s   = 11'd0;
            time_up_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_nxt_s   = ST_RUN;
                        presc_nxt_s   = '0;
                        timer_nxt_s   = 11'd0;
                        time_up_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (solved) begin
                        state_nxt_s = ST_SCORE;
                    end else if (pause) begin
                        state_nxt_s = ST_PAUSE;
                    end else if (presc_r == PRESC_MAX) begin
                        presc_nxt_s = '0;
                        timer_nxt_s = timer_inc_s;
                        if (timer_inc_s == LIMIT_V) begin
                            state_nxt_s   = ST_SCORE;
                            time_up_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else begin
                        presc_nxt_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_PAUSE;
                    end
                end
                ST_SCORE: begin
                    state_nxt_s = ST_DONE;
                    latch_s     = 1'b1;
                end
                default: begin
                    state_nxt_s   = ST_IDLE;
                    presc_nxt_s   = '0;
                    timer_nxt_s   = 11'd0;
                    time_up_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Game state registers; status outputs are registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            presc_r       <= '0;
            timer_r       <= 11'd0;
            time_up_r     <= 1'b0;
            final_score_r <= 7'd0;
            running_r     <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            presc_r   <= presc_nxt_s;
            timer_r   <= timer_nxt_s;
            time_up_r <= time_up_nxt_s;
            running_r <= (state_nxt_s == ST_RUN);
            done_r    <= (state_nxt_s == ST_DONE);
            if (latch_s) begin
                final_score_r <= score_s;
            end
        end
    end

    assign timer       = timer_r;
    assign running     = running_r;
    assign time_up     = time_up_r;
    assign done        = done_r;
    assign final_score = final_score_r;

`ifdef GAME_TIMER_BEST_SCORE_EN
    logic [6:0] best_score_r;
    logic       new_record_r;

    // Best score only moves on a strictly higher result; the pulse lasts one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_score_r <= 7'd0;
            new_record_r <= 1'b0;
        end else if (latch_s && (score_s > best_score_r)) begin
            best_score_r <= score_s;
            new_record_r <= 1'b1;
        end else begin
            new_record_r <= 1'b0;
        end
    end

    assign best_score = best_score_r;
    assign new_record = new_record_r;
`else
    assign best_score = 7'd0;
    assign new_record = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Scoreboard bench for game_timer_ctrl (CLK_HZ=4, 30-minute limit => LIMIT=1800).
module tb_game_timer_ctrl;

`ifdef GAME_TIMER_BEST_SCORE_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        solved = 1'b0;
    logic        abort = 1'b0;
    logic [10:0] timer;
    logic        running;
    logic        time_up;
    logic        done;
    logic [6:0]  final_score;
    logic [6:0]  best_score;
    logic        new_record;

    game_timer_ctrl #(
        .CLK_HZ             (4),
        .TIME_LIMIT_MINUTES (30)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .pause       (pause),
        .solved      (solved),
        .abort       (abort),
        .timer       (timer),
        .running     (running),
        .time_up     (time_up),
        .done        (done),
        .final_score (final_score),
        .best_score  (best_score),
        .new_record  (new_record)
    );

    always #5 clk = ~clk;

    typedef struct {
        int score;
        int tup;
        int tmr;
        int best;
        int nr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   exp_best = 0;
    logic done_prev = 1'b0;
    logic nr_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_game(input int score, input int tup, input int tmr);
        exp_t e;
        int nr;
        nr = (BEST_EN && score > exp_best) ? 1 : 0;
        if (nr != 0) exp_best = score;
        e.score = score;
        e.tup   = tup;
        e.tmr   = tmr;
        e.best  = BEST_EN ? exp_best : 0;
        e.nr    = nr;
        sb_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_timer(input int v, input int budget);
        int k = 0;
        while (timer != 11'(v) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_timer", int'(timer), v);
    endtask

    task automatic play_solved(input int t, input int score);
        pulse_start();
        wait_timer(t, t * 4 + 20);
        push_game(score, 0, t);
        solved = 1'b1;
        @(negedge clk);
        solved = 1'b0;
        chk("score_cycle_running", int'(running), 0);
        chk("score_cycle_done", int'(done), 0);
        @(negedge clk);
        chk("done_two_after_solved", int'(done), 1);
    endtask

    // Monitor: compares each completed game against the scoreboard on done rising.
    always @(negedge clk) begin
        if (nr_prev) chk("new_record_width", int'(new_record), 0);
        if (reset_n && done && !done_prev) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("final_score", int'(final_score), mon_e.score);
                chk("time_up", int'(time_up), mon_e.tup);
                chk("frozen_timer", int'(timer), mon_e.tmr);
                chk("best_score", int'(best_score), mon_e.best);
                chk("new_record", int'(new_record), mon_e.nr);
            end
        end
        done_prev <= done;
        nr_prev   <= new_record;
    end

    initial begin
        int bad;
        int k;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_timer", int'(timer), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_time_up", int'(time_up), 0);
        chk("rst_final", int'(final_score), 0);
        chk("rst_best", int'(best_score), 0);
        chk("rst_new_record", int'(new_record), 0);

        // Solved at the grace boundary: full marks.
        play_solved(60, 100);
        tick3: repeat (3) @(negedge clk);

        // Time limit: timer saturates at 1800, score zero.
        push_game(0, 1, 1800);
        pulse_start();
        k = 0;
        while (!done && k < 7300) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_done", int'(done), 1);
        repeat (5) @(negedge clk);
        chk("timeout_timer_held", int'(timer), 1800);
        chk("timeout_time_up", int'(time_up), 1);

        // Pause holds prescaler and timer; resume continues the partial second.
        pulse_start();
        wait_timer(10, 60);
        repeat (2) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        chk("pause_running", int'(running), 0);
        bad = 0;
        for (int i = 0; i < 39; i++) begin
            @(negedge clk);
            if (timer != 11'd10) bad++;
        end
        chk("pause_hold_timer", bad, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("resume_running", int'(running), 1);
        chk("resume_timer_e0", int'(timer), 10);
        @(negedge clk);
        chk("resume_timer_e1", int'(timer), 10);
        @(negedge clk);
        chk("resume_timer_e2", int'(timer), 11);
        wait_timer(15, 40);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_running", int'(running), 0);
        chk("abort_timer", int'(timer), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_final_kept", int'(final_score), 0);

        // Asynchronous reset mid-game.
        pulse_start();
        wait_timer(200, 900);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_timer", int'(timer), 0);
        chk("areset_running", int'(running), 0);
        chk("areset_done", int'(done), 0);
        chk("areset_time_up", int'(time_up), 0);
        chk("areset_final", int'(final_score), 0);
        chk("areset_best", int'(best_score), 0);
        chk("areset_new_record", int'(new_record), 0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_best = 0;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", int'(running), 0);

        // Best-score sequence: 50, 100, 50.
        play_solved(930, 50);
        repeat (3) @(negedge clk);
        play_solved(60, 100);
        repeat (3) @(negedge clk);
        play_solved(930, 50);
        repeat (3) @(negedge clk);

        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_timer_ctrl.md
GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning clk cycles per game second.
REQ-002 SHALL have parameter TIME_LIMIT_MINUTES, default 30, meaning game length limit; legal range 2..34 so that LIMIT = TIME_LIMIT_MINUTES*60 fits in 11 bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  sampled each cycle: start a game (IDLE/DONE) or resume (PAUSE).
REQ-006 SHALL have port pause  input  1  sampled each cycle: suspend a running game.
REQ-007 SHALL have port solved  input  1  sampled each cycle: puzzle completed.
REQ-008 SHALL have port abort  input  1  sampled each cycle: abandon the game, return to IDLE.
REQ-009 SHALL have port timer  output  11  elapsed game seconds.
REQ-010 SHALL have port running  output  1  high in RUN.
REQ-011 SHALL have port time_up  output  1  high in DONE when the game ended by time limit.
REQ-012 SHALL have port done  output  1  high in DONE.
REQ-013 SHALL have port final_score  output  7  latched score, 0..100.
REQ-014 SHALL have port best_score  output  7  highest final_score since reset.
REQ-015 SHALL have port new_record  output  1  one-cycle pulse when best_score increases.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, PAUSE, SCORE, DONE.
REQ-017 Priority per cycle SHALL be abort > solved > pause > start; abort in any state SHALL go to IDLE, clear timer and prescaler, and leave final_score unchanged.
REQ-018 IDLE/DONE + start SHALL go to RUN and clear timer, prescaler, time_up; start in RUN/SCORE SHALL be ignored.
REQ-019 In RUN a prescaler SHALL count 0..CLK_HZ-1; the wrap cycle SHALL increment timer by 1.
REQ-020 When timer increments to LIMIT the FSM SHALL go to SCORE with time_up set; timer SHALL never exceed LIMIT.
REQ-021 RUN + solved SHALL go to SCORE with timer frozen at its current value; a tick in that same cycle SHALL be discarded.
REQ-022 RUN + pause SHALL go to PAUSE; prescaler and timer SHALL hold; PAUSE + start SHALL return to RUN continuing from the held prescaler value.
REQ-023 solved and pause in PAUSE SHALL be ignored.
REQ-024 SCORE SHALL last exactly one cycle, then go to DONE and latch final_score on that transition.
REQ-025 Score SHALL be: 100 if timer <= 60; 0 if timer >= LIMIT; else 100 - ((timer-60)*100)/(LIMIT-60), evaluated with an 18-bit product, integer truncating division.
REQ-026 done SHALL assert the cycle after SCORE, i.e. 2 cycles after solved is sampled.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, timer=0, prescaler=0, final_score=0, best_score=0, running=0, time_up=0, done=0, new_record=0.
REQ-028 Reset mid-game SHALL discard all game state; no score SHALL be latched.

Configuration
REQ-029 Macro GAME_TIMER_BEST_SCORE_EN defined: on SCORE->DONE, if the new final_score > best_score, best_score SHALL load it and new_record SHALL pulse for one cycle; equality SHALL not update.
REQ-030 Macro undefined: best_score SHALL be constant 0, new_record constant 0, no best-score register present.

Structure
REQ-031 Shared package game_pkg SHALL hold the FSM state typedef, MAX_SCORE=100 and GRACE_SECONDS=60.
REQ-032 Score arithmetic SHALL be a combinational sub-module score_eval (inputs timer; parameter LIMIT; output 7-bit score).

Verification (CLK_HZ=4, TIME_LIMIT_MINUTES=30, LIMIT=1800)
REQ-033 start, solved when timer=60 -> SCORE 1 cycle, done=1, final_score=100, time_up=0.
REQ-034 start, solved when timer=930 -> final_score=50 ((870*100)/1740=50).
REQ-035 start, no solved -> timer stops at 1800, time_up=1, done=1, final_score=0.
REQ-036 pause at timer=10 for 40 cycles, then start -> timer still 10 throughout pause, next increment at remaining prescaler count; abort at timer=15 -> IDLE, timer=0, done=0.
REQ-037 reset_n low mid-RUN at timer=200 -> all outputs zero immediately, FSM IDLE.
REQ-038 With GAME_TIMER_BEST_SCORE_EN: games scoring 50, 100, 50 -> best_score 50, 100, 100; new_record pulses after games 1 and 2 only.
